// File: rtl/multiclickreg.sv
// multiclickreg: multichannel pulse registrar with a free-running timestamp
// timer, wrap markers, a record FIFO drained over valid/ready, and drop
// accounting when the FIFO overflows.
module multiclickreg #(
  parameter  int CHANNELS   = 4,
  parameter  int TIMER_W    = 39,
  parameter  int FIFO_DEPTH = 16,
  localparam int DATA_W     = CHANNELS + 1 + TIMER_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] channel,
  input  logic [CHANNELS-1:0] chan_mask,
  input  logic                edge_mode,
  input  logic                clear,
  input  logic                operate,
  output logic [DATA_W-1:0]   data,
  output logic                valid,
  input  logic                ready,
  output logic [15:0]         lost_count,
  output logic                overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  // Registered state and its next-state values
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [CHANNELS-1:0] chan_q, chan_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [15:0]         lost_count_q, lost_count_d;
  logic                overflow_q, overflow_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  // Combinational control signals
  logic [CHANNELS-1:0] hits_s;
  logic                wrap_s;
  logic                push_req_s;
  logic                valid_s;
  logic                pop_s;
  logic                full_s;
  logic                wr_en_s;
  logic                drop_s;
  logic [DATA_W-1:0]   rec_s;

  // Hit detection and record assembly from the current sample and timer
  always_comb begin
    hits_s     = {CHANNELS{1'b0}};
    wrap_s     = 1'b0;
    push_req_s = 1'b0;
    rec_s      = {DATA_W{1'b0}};
    if (edge_mode) begin
      hits_s = chan_mask & channel & ~chan_q;
    end else begin
      hits_s = chan_mask & channel;
    end
    wrap_s     = (timer_q == {TIMER_W{1'b0}});
    push_req_s = (hits_s != {CHANNELS{1'b0}}) || (wrap_s && operate);
    rec_s      = {hits_s, wrap_s, timer_q};
  end

  // FIFO handshake: pop only a record already visible, accept a push into a
  // full FIFO only when a pop frees a slot in the same cycle
  always_comb begin
    valid_s = (count_q != {CW{1'b0}});
    full_s  = (count_q == CW'(FIFO_DEPTH));
    pop_s   = valid_s && ready;
    wr_en_s = 1'b0;
    drop_s  = 1'b0;
    if (reset_n && push_req_s) begin
      if (!full_s || pop_s) begin
        wr_en_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      wr_en_s = 1'b0;
      drop_s  = 1'b0;
    end
  end

  // Next-state for timer, previous sample, FIFO pointers and drop accounting
  always_comb begin
    timer_d      = timer_q;
    chan_d       = channel;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    lost_count_d = lost_count_q;
    overflow_d   = overflow_q;

    if (clear) begin
      timer_d = {TIMER_W{1'b0}};
    end else begin
      timer_d = timer_q + TIMER_W'(1);
    end

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (drop_s) begin
      overflow_d = 1'b1;
      if (lost_count_q != 16'hFFFF) begin
        lost_count_d = lost_count_q + 16'd1;
      end else begin
        lost_count_d = lost_count_q;
      end
    end else begin
      overflow_d   = overflow_q;
      lost_count_d = lost_count_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timer_q      <= {TIMER_W{1'b0}};
      chan_q       <= {CHANNELS{1'b0}};
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      count_q      <= {CW{1'b0}};
      lost_count_q <= 16'd0;
      overflow_q   <= 1'b0;
    end else begin
      timer_q      <= timer_d;
      chan_q       <= chan_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      lost_count_q <= lost_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Record storage; contents need no reset since reads are gated by valid
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= rec_s;
    end
  end

  // Output the FIFO head, forced to zero when nothing is buffered
  always_comb begin
    valid      = valid_s;
    lost_count = lost_count_q;
    overflow   = overflow_q;
    if (valid_s) begin
      data = mem_q[rd_ptr_q];
    end else begin
      data = {DATA_W{1'b0}};
    end
  end

endmodule

// File: doc/multiclickreg.md
# multiclickreg

Parametrised multichannel pulse registration and time-stamping block, successor to the fixed 4-channel registrar. Samples CHANNELS pulse inputs every clock, applies a per-channel enable mask and optional rising-edge detection, and stamps each hit against a free-running timer. Emits a marker record on every timer wrap. Records are buffered in a FIFO and drained over a valid/ready handshake to the host-side readout logic, with drop accounting on overflow.

## Interface
- CHANNELS, 4: number of pulse inputs (1..16).
- TIMER_W, 39: timer and timestamp width.
- FIFO_DEPTH, 16: record buffer depth; power of two, at least 2.
- DATA_W, CHANNELS+1+TIMER_W: derived record width; not overridable.

- clk  in  1  sole clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- channel  in  CHANNELS  pulse inputs, already synchronised to clk.
- chan_mask  in  CHANNELS  1 = channel enabled.
- edge_mode  in  1  0 = level (every high cycle is a hit); 1 = rising edge only.
- clear  in  1  zeroes the timer.
- operate  in  1  enables wrap-marker records.
- data  out  DATA_W  head record: [TIMER_W-1:0] timestamp, [TIMER_W] wrap flag, [DATA_W-1:TIMER_W+1] hit bits.
- valid  out  1  head record present.
- ready  in  1  consumer accepts head record when valid & ready.
- lost_count  out  16  records dropped because the FIFO was full; saturates at 16'hFFFF.
- overflow  out  1  sticky; set on first drop.

## Operation
- Timer: increments by 1 each cycle and wraps modulo 2^TIMER_W. When clear=1, timer loads 0 at the next edge.
- Previous-sample register chan_q <= channel every cycle, independent of mask and edge_mode.
- Hits: hits = chan_mask & (edge_mode ? channel & ~chan_q : channel).
- Push condition: hits != 0, or (timer == 0 and operate = 1).
- Pushed record: timestamp = current timer value (pre-increment, pre-clear). Wrap flag = (timer == 0). Hit bits = hits.
- A hit on timer == 0 produces one combined record, not two. With operate = 0, timer == 0 and no hits: no record.
- FIFO push with FIFO full and no pop in the same cycle: record dropped, lost_count increments (saturating), overflow sets.
- Push with FIFO full and a pop in the same cycle: push is accepted, nothing is dropped.
- Push and pop on an empty FIFO: the pushed record is not visible until the next cycle, so there is no pop.
- Output: data and valid present the FIFO head. data is held stable while valid & ~ready. data = 0 whenever valid = 0.
- Reset (reset_n=0) takes priority over clear. It zeroes the timer, chan_q, FIFO pointers, lost_count and overflow, drops all buffered records, and suppresses any push in the same cycle.

## Timing
- Reset values: valid=0, data=0, lost_count=0, overflow=0, timer=0, chan_q=0.
- Ingress latency: channel sampled at edge k. Record written at edge k. valid=1 after edge k if the FIFO was empty.
- Throughput: one record per cycle in and out, sustained, with no bubbles.
- Pop: takes effect at the edge where valid & ready. Next head (or valid=0) is visible after that edge.
- clear asserted at edge k: a record captured at edge k carries the old timer value T. The record at edge k+1 carries 0 and wrap flag 1 if operate=1.
- Natural wrap: the cycle after timer = 2^TIMER_W-1 has timer = 0, and a marker record is written if operate=1.
- reset_n released at edge r: timer=0 during the following cycle. A marker is pushed at edge r+1 if operate=1.
- edge_mode toggled mid-stream: takes effect combinationally the same cycle, using the already-registered chan_q.

## Test plan
- Defaults, operate=0, edge_mode=0, mask=4'hF, channel=4'b0101 held 3 cycles from timer=100 -> three records {hits=0101, wrap=0, ts=100,101,102}; valid stays 1 with ready=1.
- Same stimulus with edge_mode=1 -> a single record {hits=0101, ts=100}. Then channel=0 for 1 cycle and 4'b0101 again at timer=104 -> record ts=104.
- mask=4'b0011, channel=4'b1100 -> no record. channel=4'b1110 at ts=50 -> record hits=0010, ts=50.
- TIMER_W=8, operate=1, no pulses -> marker {hits=0, wrap=1, ts=0} every 256 cycles. channel=0001 at the wrap cycle -> one record {hits=0001, wrap=1, ts=0}.
- ready=0, 20 single-cycle hits -> 16 records buffered, lost_count=4, overflow=1. Raise ready -> the 16 records drain in order with ts strictly increasing, then valid=0 and data=0.
- FIFO full, then push and pop in the same cycle -> no drop, lost_count unchanged. reset_n=0 mid-drain -> valid=0, lost_count=0, overflow=0 after the edge; timer restarts at 0.
